// File: rtl/fifo_frame_pkg.sv
// Shared types and default parameter values for the FIFO frame reader.
package fifo_frame_pkg;

  localparam int          DATA_WIDTH_DEF = 32;
  localparam int          LEN_WIDTH_DEF  = 16;
  localparam logic [15:0] HDR_MARKER_DEF = 16'hA5A5;

  // Frame sequencer states: header word, payload words, checksum trailer.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } state_e;

endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry skid buffer between the FIFO read data and the output stream.
// It absorbs the one-cycle FIFO read latency so payload can stream at one
// word per cycle while still honouring downstream back-pressure.
module frame_skid_buf
  import fifo_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + 2'(push) - 2'(pop);
  end

  // Pointer and occupancy registers, cleared by the shared reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the data entries are deliberately not reset; occupancy alone
    // decides whether an entry is meaningful, so resetting them buys nothing.
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

  // A push into a full buffer without a simultaneous pop would lose a word.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && occ_q == 2'd2 && !pop))
    else $error("frame_skid_buf: push while full");

  // Popping an empty buffer would present stale data as a payload word.
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && occ_q == 2'd0))
    else $error("frame_skid_buf: pop while empty");

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side frame sequencer: pops payload words from the sample FIFO and emits
// header / payload / XOR-checksum trailer frames on a ready/valid stream.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int          LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter logic [15:0] HDR_MARKER = HDR_MARKER_DEF
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [LEN_WIDTH-1:0]  FRAME_LEN,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_Q,
  output logic                  FIFO_RE,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_SOF,
  output logic                  OUT_EOF,
  output logic [LEN_WIDTH-1:0]  FRAME_CNT,
  output logic                  BUSY
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  req_cnt_q, req_cnt_d;
  logic [LEN_WIDTH-1:0]  sent_cnt_q, sent_cnt_d;
  logic [LEN_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] buf_head;
  logic [1:0]            buf_occ;
  logic                  pop;
  logic                  start_ok;
  logic                  start_frame;
  logic [2:0]            pending;

  assign start_ok   = ENABLE && (FRAME_LEN != '0);
  assign inflight_d = FIFO_RE;
  assign FRAME_CNT  = frame_cnt_q;
  assign BUSY       = (state_q != IDLE);

  // The read issued last cycle lands in the buffer this cycle, so the
  // in-flight flag is the buffer's push.
  frame_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (CLOCK),
    .rst       (RESET),
    .push      (inflight_q),
    .push_data (FIFO_Q),
    .pop       (pop),
    .head      (buf_head),
    .occ       (buf_occ)
  );

  // Next-state, FIFO read request and stream outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    req_cnt_d   = req_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    pending     = 3'd0;
    FIFO_RE     = 1'b0;
    OUT_VALID   = 1'b0;
    OUT_SOF     = 1'b0;
    OUT_EOF     = 1'b0;
    OUT_DATA    = '0;

    unique case (state_q)
      IDLE: begin
        if (start_ok) start_frame = 1'b1;
      end

      HEADER: begin
        OUT_VALID = 1'b1;
        OUT_SOF   = 1'b1;
        OUT_DATA  = DATA_WIDTH'({HDR_MARKER, frame_cnt_q});
        if (OUT_READY) state_d = PAYLOAD;
      end

      PAYLOAD: begin
        OUT_VALID = (buf_occ != 2'd0);
        OUT_DATA  = buf_head;
        pop       = OUT_VALID && OUT_READY;
        // Words that will sit in the buffer after this edge: a new read is
        // only safe while that leaves room for its data next cycle.
        pending   = 3'(buf_occ) + 3'(inflight_q) - 3'(pop);
        FIFO_RE   = !FIFO_EMPTY && (req_cnt_q < len_q) && (pending < 3'd2);
        if (FIFO_RE) req_cnt_d = req_cnt_q + LEN_WIDTH'(1);
        if (pop) begin
          csum_d     = csum_q ^ buf_head;
          sent_cnt_d = sent_cnt_q + LEN_WIDTH'(1);
          if (sent_cnt_q + LEN_WIDTH'(1) == len_q) state_d = TRAILER;
        end
      end

      TRAILER: begin
        OUT_VALID = 1'b1;
        OUT_EOF   = 1'b1;
        OUT_DATA  = csum_q;
        if (OUT_READY) begin
          frame_cnt_d = frame_cnt_q + LEN_WIDTH'(1);
          if (start_ok) start_frame = 1'b1;
          else          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Frame start: FRAME_LEN is sampled only here and ignored mid-frame.
    if (start_frame) begin
      state_d    = HEADER;
      len_d      = FRAME_LEN;
      csum_d     = '0;
      req_cnt_d  = '0;
      sent_cnt_d = '0;
    end
  end

  // Sequencer registers; reset also drops any outstanding FIFO read.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      len_q       <= '0;
      req_cnt_q   <= '0;
      sent_cnt_q  <= '0;
      frame_cnt_q <= '0;
      csum_q      <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      req_cnt_q   <= req_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      csum_q      <= csum_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader: a FIFO model feeds the DUT, and a
// frame-level reference (header, the FIFO words in pop order, XOR trailer)
// checks every stream transfer.
module tb_fifo_frame_reader;

  logic        CLOCK      = 1'b0;
  logic        RESET      = 1'b0;
  logic        ENABLE     = 1'b0;
  logic [15:0] FRAME_LEN  = 16'd0;
  logic        FIFO_EMPTY = 1'b1;
  logic [31:0] FIFO_Q     = 32'd0;
  logic        OUT_READY  = 1'b1;
  logic        FIFO_RE;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_SOF;
  logic        OUT_EOF;
  logic [15:0] FRAME_CNT;
  logic        BUSY;

  fifo_frame_reader dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_Q     (FIFO_Q),
    .FIFO_RE    (FIFO_RE),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_SOF    (OUT_SOF),
    .OUT_EOF    (OUT_EOF),
    .FRAME_CNT  (FRAME_CNT),
    .BUSY       (BUSY)
  );

  initial forever #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO contents and the words it has handed to the DUT, in order.
  logic [31:0] fifo_q    [$];
  logic [31:0] delivered [$];
  // Observed stream log.
  logic [31:0] out_log   [$];
  logic        sof_log   [$];
  logic        eof_log   [$];
  int          pay_cyc   [$];
  int hdr_cnt, trl_cnt, pay_cnt, re_total, cyc;
  bit re_pending, rand_ready;

  // Frame-level reference state.
  int          pos, cur_len, exp_len, re_frame;
  logic [15:0] seq;
  logic [31:0] csum;
  logic [31:0] m_ew;
  logic        m_es, m_ee;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic        prev_sof, prev_eof;

  // FIFO model: a read requested in one cycle presents its word the next.
  initial forever begin
    @(posedge CLOCK);
    #1;
    if (RESET) begin
      re_pending = 1'b0;
    end else if (re_pending) begin
      re_pending = 1'b0;
      if (fifo_q.size() != 0) begin
        FIFO_Q = fifo_q.pop_front();
        delivered.push_back(FIFO_Q);
      end
    end
    FIFO_EMPTY = (fifo_q.size() == 0);
  end

  // Downstream ready driver and cycle counter.
  initial forever begin
    @(posedge CLOCK);
    #1;
    cyc++;
    OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: checks the stream against the frame reference each cycle.
  initial forever begin
    @(negedge CLOCK);
    if (RESET) begin
      pos = 0; seq = 16'd0; csum = 32'd0; re_frame = 0;
      delivered.delete();
      re_pending = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (FIFO_RE) begin
        check("re_while_empty", 32'(FIFO_EMPTY), 32'd0);
        re_pending = 1'b1;
        re_total++;
        re_frame++;
      end
      check("frame_cnt", 32'(FRAME_CNT), 32'(seq));
      if (prev_stall) begin
        check("hold_valid", 32'(OUT_VALID), 32'd1);
        check("hold_data", OUT_DATA, prev_data);
        check("hold_sof", 32'(OUT_SOF), 32'(prev_sof));
        check("hold_eof", 32'(OUT_EOF), 32'(prev_eof));
      end
      if (OUT_VALID && OUT_READY) begin
        if (pos == 0) begin
          m_ew = {16'hA5A5, seq}; m_es = 1'b1; m_ee = 1'b0;
        end else if (pos <= cur_len) begin
          check("payload_fetched", 32'(delivered.size() != 0), 32'd1);
          m_ew = (delivered.size() != 0) ? delivered.pop_front() : 32'hDEAD_BEEF;
          m_es = 1'b0; m_ee = 1'b0;
        end else begin
          m_ew = csum; m_es = 1'b0; m_ee = 1'b1;
        end
        check("out_data", OUT_DATA, m_ew);
        check("out_sof", 32'(OUT_SOF), 32'(m_es));
        check("out_eof", 32'(OUT_EOF), 32'(m_ee));
        out_log.push_back(OUT_DATA);
        sof_log.push_back(OUT_SOF);
        eof_log.push_back(OUT_EOF);
        if (pos == 0) begin
          hdr_cnt++; cur_len = exp_len; csum = 32'd0; re_frame = 0; pos = 1;
        end else if (pos <= cur_len) begin
          csum = csum ^ m_ew; pay_cnt++; pay_cyc.push_back(cyc); pos++;
        end else begin
          trl_cnt++;
          check("re_per_frame", 32'(re_frame), 32'(cur_len));
          seq++; pos = 0;
        end
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
      prev_sof   = OUT_SOF;
      prev_eof   = OUT_EOF;
    end
  end

  function automatic int cnt_of(input int kind);
    case (kind)
      0:       return hdr_cnt;
      1:       return trl_cnt;
      default: return pay_cnt;
    endcase
  endfunction

  // Bounded wait for an event counter (0 header, 1 trailer, 2 payload).
  task automatic wait_evt(input int kind, input int target, input string name);
    int budget = 0;
    while (cnt_of(kind) < target && budget < 3000) begin
      @(negedge CLOCK);
      #1;
      budget++;
    end
    check(name, 32'(cnt_of(kind)), 32'(target));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLOCK);
      #1;
    end
  endtask

  task automatic clear_logs();
    out_log.delete(); sof_log.delete(); eof_log.delete(); pay_cyc.delete();
    hdr_cnt = 0; trl_cnt = 0; pay_cnt = 0; re_total = 0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    #1;
    RESET = 1'b1; ENABLE = 1'b0; rand_ready = 1'b0;
    fifo_q.delete();
    idle(2);
    RESET = 1'b0;
    clear_logs();
  endtask

  // One frame started by a pulse of ENABLE; FRAME_LEN may change after start.
  task automatic run_frame(input int len, input int len_after, input string tag);
    int base = hdr_cnt;
    exp_len   = len;
    FRAME_LEN = 16'(len);
    ENABLE    = 1'b1;
    wait_evt(0, base + 1, {tag, "_hdr"});
    ENABLE    = 1'b0;
    FRAME_LEN = 16'(len_after);
    wait_evt(1, base + 1, {tag, "_trl"});
  endtask

  logic [31:0] t1_exp [6];

  initial begin
    #1 RESET = 1'b1;
    #2;
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_data", OUT_DATA, 32'd0);
    check("rst_re", 32'(FIFO_RE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_cnt", 32'(FRAME_CNT), 32'd0);
    idle(2);
    RESET = 1'b0;
    clear_logs();

    // FRAME_LEN=0 never starts a frame.
    FRAME_LEN = 16'd0; ENABLE = 1'b1;
    idle(4);
    check("len0_idle", 32'(BUSY), 32'd0);
    ENABLE = 1'b0;

    // Basic frame 1,2,3,4 with literal expectations.
    do_reset();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(32'(i));
    run_frame(4, 4, "t1");
    idle(3);
    t1_exp = '{32'hA5A5_0000, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4};
    check("t1_words", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("t1_stream", out_log[i], t1_exp[i]);
    check("t1_sof", 32'(sof_log[0]), 32'd1);
    check("t1_eof", 32'(eof_log[5]), 32'd1);
    check("t1_frame_cnt", 32'(FRAME_CNT), 32'd1);
    check("t1_busy", 32'(BUSY), 32'd0);

    // Eight payload words stream on consecutive cycles.
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    run_frame(8, 8, "t2");
    check("t2_pay_cnt", 32'(pay_cnt), 32'd8);
    check("t2_back_to_back", 32'(pay_cyc[7] - pay_cyc[0]), 32'd7);

    // Random back-pressure, FRAME_LEN changed mid-frame (ignored).
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) fifo_q.push_back($urandom);
    run_frame(16, 5, "t3");
    rand_ready = 1'b0;
    check("t3_re_pulses", 32'(re_total), 32'd16);
    check("t3_pay_cnt", 32'(pay_cnt), 32'd16);
    check("t3_all_used", 32'(delivered.size()), 32'd0);

    // FIFO runs dry after two words for ten cycles.
    do_reset();
    fifo_q.push_back(32'h11); fifo_q.push_back(32'h22);
    exp_len = 4; FRAME_LEN = 16'd4; ENABLE = 1'b1;
    wait_evt(0, 1, "t4_hdr");
    ENABLE = 1'b0;
    wait_evt(2, 2, "t4_first2");
    repeat (10) begin
      @(negedge CLOCK);
      #1;
      check("t4_stall_valid", 32'(OUT_VALID), 32'd0);
      check("t4_stall_re", 32'(FIFO_RE), 32'd0);
    end
    fifo_q.push_back(32'h44); fifo_q.push_back(32'h88);
    wait_evt(1, 1, "t4_trl");
    check("t4_checksum", out_log[5], 32'h0000_00FF);
    idle(3);
    check("t4_busy", 32'(BUSY), 32'd0);

    // Back-to-back one-word frames, ENABLE dropped during the third.
    do_reset();
    for (int i = 0; i < 3; i++) fifo_q.push_back(32'(7 + i));
    exp_len = 1; FRAME_LEN = 16'd1; ENABLE = 1'b1;
    wait_evt(0, 3, "t5_hdr3");
    ENABLE = 1'b0;
    wait_evt(1, 3, "t5_trl3");
    idle(5);
    check("t5_seq0", out_log[0], 32'hA5A5_0000);
    check("t5_seq1", out_log[3], 32'hA5A5_0001);
    check("t5_seq2", out_log[6], 32'hA5A5_0002);
    check("t5_no_more", 32'(hdr_cnt), 32'd3);
    check("t5_busy", 32'(BUSY), 32'd0);

    // Reset in the middle of a payload.
    do_reset();
    fifo_q.push_back(32'h5); fifo_q.push_back(32'h6);
    run_frame(2, 2, "t6a");
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    exp_len = 8; FRAME_LEN = 16'd8; ENABLE = 1'b1;
    wait_evt(0, 2, "t6_hdr2");
    ENABLE = 1'b0;
    wait_evt(2, 5, "t6_mid");
    @(posedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    check("t6_valid", 32'(OUT_VALID), 32'd0);
    check("t6_data", OUT_DATA, 32'd0);
    check("t6_sof", 32'(OUT_SOF), 32'd0);
    check("t6_eof", 32'(OUT_EOF), 32'd0);
    check("t6_re", 32'(FIFO_RE), 32'd0);
    check("t6_cnt", 32'(FRAME_CNT), 32'd0);
    check("t6_busy", 32'(BUSY), 32'd0);
    fifo_q.delete();
    idle(2);
    RESET = 1'b0;
    clear_logs();
    fifo_q.push_back(32'hAA); fifo_q.push_back(32'hBB);
    run_frame(2, 2, "t6b");
    check("t6_hdr_after", out_log[0], 32'hA5A5_0000);
    check("t6_csum_after", out_log[3], 32'h0000_0011);

    // Randomised frames with random back-pressure and FIFO gaps.
    rand_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int len = int'($urandom_range(1, 12));
      int half = len / 2;
      for (int i = 0; i < half; i++) fifo_q.push_back($urandom);
      exp_len = len; FRAME_LEN = 16'(len); ENABLE = 1'b1;
      wait_evt(0, hdr_cnt + 1, "rnd_hdr");
      ENABLE = 1'b0;
      idle(int'($urandom_range(0, 5)));
      for (int i = half; i < len; i++) fifo_q.push_back($urandom);
      wait_evt(1, hdr_cnt, "rnd_trl");
    end
    rand_ready = 1'b0;
    idle(3);
    check("rnd_frame_cnt", 32'(FRAME_CNT), 32'd7);
    check("rnd_busy", 32'(BUSY), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
